// File: rtl/pivot_capture.sv
// Pivot row/column extractor: watches the row-major tile stream and writes
// pivot row k or pivot column k, packed L elements per word, to the pivot RAM.
module pivot_capture #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned L          = 4,
  parameter int unsigned B          = 32,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned K_WIDTH    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  col_mode,
  input  logic [K_WIDTH-1:0]    k,
  input  logic                  in_valid,
  input  logic [L*WIDTH-1:0]    in_data,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] a_w,
  output logic [L*WIDTH-1:0]    di,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LANE_BITS = $clog2(L);
  localparam int unsigned DW        = L * WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CB_LAST = ADDR_WIDTH'(B / L - 1);
  localparam logic [K_WIDTH-1:0]    R_LAST  = K_WIDTH'(B - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [K_WIDTH-1:0]    k_q, k_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] cb_q, cb_d;
  logic [K_WIDTH-1:0]    r_q, r_d;
  logic [DW-1:0]         pack_q, pack_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] a_w_q, a_w_d;
  logic [DW-1:0]         di_q, di_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [WIDTH-1:0]      lane_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      mode_q  <= 1'b0;
      cb_q    <= '0;
      r_q     <= '0;
      pack_q  <= '0;
      we_q    <= 1'b0;
      a_w_q   <= '0;
      di_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      cb_q    <= cb_d;
      r_q     <= r_d;
      pack_q  <= pack_d;
      we_q    <= we_d;
      a_w_q   <= a_w_d;
      di_q    <= di_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    mode_d   = mode_q;
    cb_d     = cb_q;
    r_d      = r_q;
    pack_d   = pack_q;
    we_d     = 1'b0;
    a_w_d    = a_w_q;
    di_d     = di_q;
    lane_sel = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          k_d     = k;
          mode_d  = col_mode;
          cb_d    = '0;
          r_d     = '0;
          pack_d  = '0;
        end
      end

      STREAM: begin
        if (in_valid) begin
          if (!mode_q) begin
            if (r_q == k_q) begin
              we_d  = 1'b1;
              a_w_d = cb_q;
              di_d  = in_data;
            end
          end else if (cb_q == ADDR_WIDTH'(k_q >> LANE_BITS)) begin
            // Pick lane k%L of this beat and drop it into pack lane r%L.
            for (int j = 0; j < int'(L); j++) begin
              if (k_q[LANE_BITS-1:0] == LANE_BITS'(j)) lane_sel = in_data[j*WIDTH +: WIDTH];
            end
            for (int j = 0; j < int'(L); j++) begin
              if (r_q[LANE_BITS-1:0] == LANE_BITS'(j)) pack_d[j*WIDTH +: WIDTH] = lane_sel;
            end
            if (r_q[LANE_BITS-1:0] == LANE_BITS'(L - 1)) begin
              we_d  = 1'b1;
              a_w_d = ADDR_WIDTH'(r_q >> LANE_BITS);
              di_d  = pack_d;
            end
          end

          if (cb_q == CB_LAST) begin
            cb_d = '0;
            r_d  = r_q + K_WIDTH'(1);
            if (r_q == R_LAST) state_d = DONE;
          end else begin
            cb_d = cb_q + ADDR_WIDTH'(1);
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == STREAM);
    done_d = (state_d == DONE);
  end

  assign we   = we_q;
  assign a_w  = a_w_q;
  assign di   = di_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pivot_capture.sv
// Directed bench for pivot_capture: row/column captures, stream gaps,
// ignored start/in_valid, mid-stream reset and back-to-back captures.
module tb_pivot_capture;

  localparam int WIDTH = 16;
  localparam int L     = 4;
  localparam int B     = 32;
  localparam int AW    = 3;
  localparam int KW    = 5;
  localparam int DW    = L * WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          col_mode = 1'b0;
  logic [KW-1:0] k = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          we;
  logic [AW-1:0] a_w;
  logic [DW-1:0] di;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  int            wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int            wr_beat[$];
  int            done_cnt;
  bit            done_we;
  int            done_beat;

  pivot_capture #(.WIDTH(WIDTH), .L(L), .B(B), .ADDR_WIDTH(AW), .K_WIDTH(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .col_mode(col_mode), .k(k),
    .in_valid(in_valid), .in_data(in_data),
    .we(we), .a_w(a_w), .di(di), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Lane j of beat b (row b/8, cb b%8) is r*32 + 4*cb + j = 4*b + j.
  function automatic logic [DW-1:0] beat_val(input int b);
    logic [DW-1:0] v;
    for (int j = 0; j < L; j++) v[j*WIDTH +: WIDTH] = WIDTH'(4 * b + j);
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_row(input int kk, input int i);
    logic [DW-1:0] v;
    for (int j = 0; j < L; j++) v[j*WIDTH +: WIDTH] = WIDTH'(kk * B + 4 * i + j);
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_col(input int kk, input int i);
    logic [DW-1:0] v;
    for (int j = 0; j < L; j++) v[j*WIDTH +: WIDTH] = WIDTH'((4 * i + j) * B + kk);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_beat.delete();
    done_cnt  = 0;
    done_we   = 1'b0;
    done_beat = -1;
  endtask

  // One clock; cur is the beat index presented at this edge (-1 if none).
  task automatic step(input int cur);
    @(posedge clk);
    #1;
    if (we === 1'b1) begin
      wr_addr.push_back(int'(a_w));
      wr_data.push_back(di);
      wr_beat.push_back(cur);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_we   = (we === 1'b1);
      done_beat = cur;
    end
  endtask

  task automatic do_start(input bit cm, input int kk);
    start    = 1'b1;
    col_mode = cm;
    k        = KW'(kk);
    step(-1);
    start    = 1'b0;
  endtask

  // Feeds beats 0..max_beats-1; returns in the done cycle or when beats run out.
  task automatic stream(input int gap_pct, input int max_beats, input int start_at);
    int b   = 0;
    int cyc = 0;
    while (b < max_beats && cyc < 4000) begin
      in_valid = (int'($urandom_range(99)) >= gap_pct);
      in_data  = beat_val(b);
      if (b == start_at) begin
        start    = 1'b1;
        col_mode = 1'b1;
        k        = KW'(3);
      end
      step(in_valid ? b : -1);
      start = 1'b0;
      if (in_valid) b++;
      cyc++;
      if (done_cnt > 0) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle_beats(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = beat_val(i);
      step(-1);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input bit cm, input int kk);
    chk({tag, "_nwr"}, 64'(wr_addr.size()), 64'd8);
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[i]), 64'(i));
      chk($sformatf("%s_data%0d", tag, i), wr_data[i], cm ? exp_col(kk, i) : exp_row(kk, i));
      chk($sformatf("%s_beat%0d", tag, i), 64'(wr_beat[i]),
          cm ? 64'((4 * i + 3) * 8 + kk / 4) : 64'(kk * 8 + i));
    end
  endtask

  initial begin
    logic [DW-1:0] first_exp;
    clear_log();

    // Reset state
    #12;
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_aw", 64'(a_w), 64'd0);
    chk("rst_di", di, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: row mode k=5, continuous stream
    clear_log();
    do_start(1'b0, 5);
    chk("t1_busy_start", 64'(busy), 64'd1);
    stream(0, 256, -1);
    check_writes("t1", 1'b0, 5);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_done_beat", 64'(done_beat), 64'd255);
    chk("t1_busy_at_done", 64'(busy), 64'd0);
    step(-1);
    chk("t1_done_pulse", 64'(done), 64'd0);

    // 2: column mode k=6
    clear_log();
    do_start(1'b1, 6);
    stream(0, 256, -1);
    check_writes("t2", 1'b1, 6);
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);
    step(-1);

    // 3: row mode k=31 with random gaps; last write lands with done
    clear_log();
    do_start(1'b0, 31);
    stream(30, 256, -1);
    check_writes("t3", 1'b0, 31);
    chk("t3_done_cnt", 64'(done_cnt), 64'd1);
    chk("t3_done_we", 64'(done_we), 64'd1);
    chk("t3_done_beat", 64'(done_beat), 64'd255);
    step(-1);

    // 4: in_valid while idle and a second start mid-stream are ignored
    clear_log();
    idle_beats(10);
    chk("t4_idle_nwr", 64'(wr_addr.size()), 64'd0);
    chk("t4_idle_busy", 64'(busy), 64'd0);
    do_start(1'b0, 2);
    stream(0, 256, 100);
    check_writes("t4", 1'b0, 2);
    chk("t4_done_cnt", 64'(done_cnt), 64'd1);
    step(-1);
    idle_beats(10);
    chk("t4_post_done_cnt", 64'(done_cnt), 64'd1);
    chk("t4_post_nwr", 64'(wr_addr.size()), 64'd8);

    // 5: reset mid-stream after 3 writes, then a clean capture
    clear_log();
    do_start(1'b0, 0);
    stream(0, 3, -1);
    chk("t5_pre_nwr", 64'(wr_addr.size()), 64'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_we", 64'(we), 64'd0);
    chk("t5_rst_aw", 64'(a_w), 64'd0);
    chk("t5_rst_di", di, 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    idle_beats(20);
    chk("t5_nostart_nwr", 64'(wr_addr.size()), 64'd0);
    chk("t5_nostart_done", 64'(done_cnt), 64'd0);
    do_start(1'b0, 0);
    stream(0, 256, -1);
    check_writes("t5", 1'b0, 0);
    chk("t5_done_cnt", 64'(done_cnt), 64'd1);

    // 6: start the cycle after done, column mode k=0
    step(-1);
    clear_log();
    do_start(1'b1, 0);
    stream(0, 256, -1);
    check_writes("t6", 1'b1, 0);
    first_exp = {16'd96, 16'd64, 16'd32, 16'd0};
    chk("t6_first_di", (wr_data.size() > 0) ? wr_data[0] : 64'hx, first_exp);
    chk("t6_done_cnt", 64'(done_cnt), 64'd1);
    step(-1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pivot_capture.md
Name: pivot_capture

Overview:
- Sits directly upstream of the pivot RAM (pivot row or pivot column buffer).
- Watches the row-major tile stream leaving the PE array and extracts either pivot row k or pivot column k.
- Packs the extracted elements L per word and drives the pivot RAM write port (we, a_w, di).
- One capture per start pulse; signals done when the whole tile has streamed past.

Parameters:
- WIDTH, 16, bits per distance element
- L, 4, elements per stream beat / per RAM word
- B, 32, tile dimension (B x B elements)
- ADDR_WIDTH, 3, RAM word address width; must equal log2(B/L)
- K_WIDTH, 5, pivot index width; must equal log2(B)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a capture
- col_mode  in  1  0 = capture row k, 1 = capture column k; sampled on start
- k  in  K_WIDTH  pivot index; sampled on start
- in_valid  in  1  stream beat valid
- in_data  in  L*WIDTH  stream beat; lane j occupies bits [j*WIDTH +: WIDTH]
- we  out  1  pivot RAM write enable
- a_w  out  ADDR_WIDTH  pivot RAM write address
- di  out  L*WIDTH  pivot RAM write data
- busy  out  1  high while capturing
- done  out  1  one-cycle pulse at end of capture

Behaviour:
- Reset: state IDLE. we=0, a_w=0, di=0, busy=0, done=0. Counters, pack register and sampled k/col_mode cleared. Reset mid-stream abandons the capture with no further writes; partial RAM contents are don't-care.
- Stream order: B rows, B/L beats per row, B*B/L beats total. Beat counter cb (0..B/L-1) and row counter r (0..B-1) advance only on in_valid in STREAM. Gaps in in_valid are allowed and stall the counters.
- FSM:
  - IDLE: start -> STREAM; latch k_q, mode_q; zero cb and r.
  - STREAM: busy=1. On the accepted beat with r=B-1 and cb=B/L-1 -> DONE.
  - DONE: done=1 for exactly this cycle; busy=0 -> IDLE.
- start is ignored in STREAM and DONE. in_valid is ignored in IDLE and DONE.
- Row mode:
  - On each accepted beat with r==k_q, the next cycle has we=1, a_w=cb, di=in_data.
  - Exactly B/L writes, addresses 0..B/L-1 in order.
- Column mode:
  - On the accepted beat with cb==k_q/L (upper bits of k_q), take lane k_q%L.
  - Place it in pack register lane r%L.
  - When r%L==L-1, the next cycle has we=1, a_w=r/L, di = completed pack (this row's element already included).
  - Exactly B/L writes, addresses 0..B/L-1 in order.
- Write latency: exactly 1 cycle after the accepted beat. we is high for one cycle per write and is 0 in all other cycles. a_w and di hold their last values when we=0.
- The final beat's write (if any) and the done pulse occur in the same cycle.
- No arithmetic on data; values pass bit-exact.

Test Plan (defaults B=32, L=4; stream element (r,c) = r*32+c, lane j of beat (r,cb) = r*32+4*cb+j):
1. start, col_mode=0, k=5, continuous in_valid -> 8 writes on the cycles after beats 40..47. a_w=0..7. di lane j = 160+4*a_w+j. done one cycle after beat 255. busy high from the cycle after start until done.
2. start, col_mode=1, k=6 -> lane 2 of beat cb=1 captured each row. Writes follow rows 3,7,...,31, with a_w=r/4 and di lane j = (4*a_w+j)*32+6. Exactly 8 writes.
3. Row mode k=31 with random in_valid gaps -> writes at a_w=0..7 only after row-31 beats; the last write coincides with done. Values are identical to the gap-free run.
4. Second start pulse during STREAM, and in_valid beats while IDLE -> no effect: counters unchanged, no extra we, a single done.
5. rst asserted mid-stream in row mode k=0, after 3 writes -> all outputs 0 immediately. Stream beats after reset produce no writes until a new start, after which a full capture completes correctly.
6. Back-to-back: start issued the cycle after done, col_mode=1, k=0 -> new capture starts cleanly. The pack register holds no stale lanes from the prior capture: the first write is di = {96,64,32,0}.
